// File: rtl/gray_pkg.sv
// Shared types and sizing helpers for the grayscale result-memory readout engine.
package gray_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_IMAGE_HEIGHT = 5;
  localparam int DEF_IMAGE_WIDTH  = 5;
  localparam int FRAME_PIXELS     = DEF_IMAGE_HEIGHT * DEF_IMAGE_WIDTH;
  localparam int PIX_CNT_W        = $clog2(FRAME_PIXELS + 1);

  function automatic int pix_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pixel_skid_fifo.sv
// Two-entry pixel FIFO that absorbs BRAM read latency and downstream stalls.
// Each entry carries the pixel and a flag marking the final pixel of the frame.
module pixel_skid_fifo
  import gray_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_push_last,
  input  logic              i_pop,
  output logic [1:0]        o_occ,
  output logic              o_head_valid,
  output logic [DATA_W-1:0] o_head_data,
  output logic              o_head_last
);

  logic [DATA_W-1:0] r_data [2];
  logic [1:0]        r_last;
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_occ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data[0] <= '0;
      r_data[1] <= '0;
      r_last    <= '0;
      r_rd_ptr  <= 1'b0;
      r_wr_ptr  <= 1'b0;
      r_occ     <= '0;
    end else begin
      // On a full FIFO a push lands in the slot being popped this same edge.
      if (i_push) begin
        r_data[r_wr_ptr] <= i_push_data;
        r_last[r_wr_ptr] <= i_push_last;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_occ <= r_occ + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_occ        = r_occ;
  assign o_head_valid = (r_occ != 2'd0);
  assign o_head_data  = r_data[r_rd_ptr];
  assign o_head_last  = o_head_valid & r_last[r_rd_ptr];

endmodule

// File: rtl/gray_frame_reader.sv
// Sweeps the result BRAM port B in raster order and streams the frame out over
// valid/ready, issuing reads only while the FIFO plus in-flight read has room.
module gray_frame_reader
  import gray_pkg::*;
#(
  parameter int IMAGE_HEIGHT     = DEF_IMAGE_HEIGHT,
  parameter int IMAGE_WIDTH      = DEF_IMAGE_WIDTH,
  parameter int DATA_COLOR_WIDTH = 8,
  parameter int ADRR_WIDTH_BRAM  = 6,
  parameter int BASE_ADDR        = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        bram_en,
  output logic                        bram_we,
  output logic [ADRR_WIDTH_BRAM-1:0]  bram_addr,
  input  logic [DATA_COLOR_WIDTH-1:0] bram_q,
  output logic [DATA_COLOR_WIDTH-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last
);

  localparam int N     = IMAGE_HEIGHT * IMAGE_WIDTH;
  localparam int CNT_W = pix_cnt_w(N);
  localparam logic [CNT_W-1:0]           N_CNT    = CNT_W'(N);
  localparam logic [CNT_W-1:0]           LAST_CNT = CNT_W'(N - 1);
  localparam logic [ADRR_WIDTH_BRAM-1:0] BASE     = ADRR_WIDTH_BRAM'(BASE_ADDR);

  if (N == 0 || BASE_ADDR + N > (1 << ADRR_WIDTH_BRAM)) begin : g_bad_cfg
    $error("gray_frame_reader: frame does not fit in the result BRAM");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_rd_cnt;
  logic [CNT_W-1:0] r_tx_cnt;
  logic             r_rd_vld_p1;
  logic             r_rd_last_p1;
  logic             w_rd_en;
  logic             w_pop;
  logic [1:0]       w_occ;
  logic [2:0]       w_level;
  logic             w_head_valid;
  logic             w_head_last;
  logic [DATA_COLOR_WIDTH-1:0] w_head_data;

  assign w_pop   = w_head_valid & out_ready;
  // Slots committed after this edge: buffered + returning read - leaving pixel.
  assign w_level = {1'b0, w_occ} + {2'b00, r_rd_vld_p1} - {2'b00, w_pop};

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_READ;
      end
      ST_READ: begin
        busy    = 1'b1;
        w_rd_en = (r_rd_cnt != N_CNT) && (w_level < 3'd2);
        if (r_rd_cnt == N_CNT) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (w_pop && (r_tx_cnt == LAST_CNT)) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_rd_cnt     <= '0;
      r_tx_cnt     <= '0;
      r_rd_vld_p1  <= 1'b0;
      r_rd_last_p1 <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rd_vld_p1  <= w_rd_en;
      r_rd_last_p1 <= w_rd_en && (r_rd_cnt == LAST_CNT);
      if (r_state == ST_DONE) begin
        r_rd_cnt <= '0;
        r_tx_cnt <= '0;
      end else begin
        if (w_rd_en) r_rd_cnt <= r_rd_cnt + 1'b1;
        if (w_pop)   r_tx_cnt <= r_tx_cnt + 1'b1;
      end
    end
  end

  // ---- stage p1: BRAM data returns and enters the FIFO ----
  pixel_skid_fifo #(
    .DATA_W (DATA_COLOR_WIDTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (r_rd_vld_p1),
    .i_push_data  (bram_q),
    .i_push_last  (r_rd_last_p1),
    .i_pop        (w_pop),
    .o_occ        (w_occ),
    .o_head_valid (w_head_valid),
    .o_head_data  (w_head_data),
    .o_head_last  (w_head_last)
  );

  assign bram_en   = w_rd_en;
  assign bram_we   = 1'b0;
  assign bram_addr = BASE + ADRR_WIDTH_BRAM'(r_rd_cnt);
  assign out_valid = w_head_valid;
  assign out_data  = w_head_data;
  assign out_last  = w_head_last;

endmodule
